pc_flow_monitor: RTL and testbench
==================================

# pc_flow_monitor

Synthesizable monitor that sits directly downstream of the chromite signal-capture interface. It consumes the stage0 fetch-PC and epoch signals and stage2 epoch-update strobes sampled each cycle. Each PC update is classified and pushed into a record FIFO that drains over a valid/ready stream to the coverage/scoreboard consumer. In parallel it checks epoch-toggle consistency, keeps sticky error and overflow flags, and maintains saturating counters.

## Interface
- XLEN, 64, PC width (32 for RV32 builds).
- DEPTH, 8, record FIFO entries; power of two, minimum 2.
- CLK  in  1  clock.
- RST_N  in  1  asynchronous active-low reset.
- rg_pc_EN  in  1  stage0 PC register write enable.
- rg_pc  in  XLEN  current PC (old value).
- rg_pc_D_IN  in  XLEN  next PC being written.
- ma_flush_fl  in  1  flush from later stage this cycle.
- rg_fence, rg_sfence  in  1 each  fence / sfence pending.
- rg_eEpoch, rg_wEpoch  in  1 each  stage0 epoch bits.
- EN_update_eEpoch, EN_update_wEpoch  in  1 each  stage2 epoch-update strobes.
- clr_sticky  in  1  clears overflow, epoch_err and drop_count.
- out_valid  out  1  record available.
- out_ready  in  1  consumer accepts record.
- out_kind  out  3  record class.
- out_pc_old, out_pc_new  out  XLEN each  PC before / after update.
- out_epochs  out  2  {eEpoch, wEpoch} at update time.
- update_count  out  32  PC updates seen, wraps.
- drop_count  out  16  records dropped, saturates at 0xFFFF.
- overflow  out  1  sticky, any drop occurred.
- epoch_err  out  2  sticky {eEpoch error, wEpoch error}.

## Operation
- Classification on each cycle with rg_pc_EN=1, in priority order:
  - FLUSH=2 if ma_flush_fl.
  - FENCE=3 if rg_fence|rg_sfence.
  - SEQ4=0 if rg_pc_D_IN == rg_pc+4, mod 2^XLEN.
  - SEQ2=1 if rg_pc_D_IN == rg_pc+2, mod 2^XLEN.
  - JUMP=4 otherwise.
  - Kinds 5–7 are never produced.
- Record = {kind, rg_pc, rg_pc_D_IN, rg_eEpoch, rg_wEpoch}, all sampled in the same cycle.
- FIFO: circular buffer with log2(DEPTH)+1-bit read/write pointers; full and empty are derived from the MSB compare; pointers wrap naturally.
- Push when rg_pc_EN. Pop when out_valid & out_ready.
- Full with push and pop in the same cycle: both are performed; no drop; occupancy is unchanged.
- Full with push and no pop: the record is dropped, drop_count += 1 (saturating), overflow set.
- update_count increments on every rg_pc_EN, including dropped records.
- Epoch checker, per epoch bit:
  - Register the previous value and the previous strobe.
  - If the strobe was high in cycle t, the bit in t+1 must equal the inverse of its value in t.
  - If the strobe was low in cycle t, the bit in t+1 must equal its value in t.
  - Any mismatch sets the corresponding epoch_err bit.
  - The check is disabled in the first cycle after reset deassertion, because there is no valid history.
- clr_sticky clears overflow, epoch_err and drop_count on the next edge. If a drop or error occurs in the same cycle, the set wins.

## Timing
- Reset (RST_N low, asynchronous):
  - FIFO empty, out_valid=0.
  - out_kind, out_pc_old, out_pc_new and out_epochs all 0.
  - All counters 0; overflow=0; epoch_err=0.
  - Epoch-history valid flag cleared.
- Reset mid-operation discards all FIFO contents immediately.
- Latency: a record pushed at edge N is visible on out_* with out_valid=1 after edge N (the cycle following capture), when the FIFO was empty. There is no bypass.
- Output data is read combinationally from the buffer at the read pointer.
- out_* stay stable while out_valid=1 and out_ready=0.
- out_valid deasserts only after the pop that empties the FIFO.
- Sustained throughput is one record per cycle when out_ready=1.
- epoch_err is set at the edge following cycle t+1, i.e. two edges after the offending strobe cycle.

## Test plan
- Sequential flow:
  - Stimulus: rg_pc 0x80000000 → 0x80000004 → 0x80000006, out_ready=1.
  - Required: records kind 0 then 1, each 1 cycle after capture.
  - update_count=2.
- Priority:
  - Stimulus: ma_flush_fl=1 and rg_fence=1 together, with rg_pc_D_IN=rg_pc+4.
  - Required: kind=2.
  - Then fence alone with a +4 target gives kind=3.
  - A target of 0x80001000 from 0x80000000 gives kind=4.
- Overflow:
  - Stimulus: DEPTH=8, out_ready=0, 10 consecutive updates.
  - Required: 8 records retained in order; drop_count=2; overflow=1.
  - clr_sticky then gives drop_count=0 and overflow=0, with FIFO contents intact.
- Full with simultaneous push and pop:
  - Stimulus: fill to 8, then push with out_ready=1 for 5 cycles.
  - Required: drop_count stays 0; occupancy stays 8; order is preserved.
- Epoch checker:
  - Stimulus: EN_update_eEpoch pulse with rg_eEpoch toggling 0→1 the next cycle.
  - Required: epoch_err=0.
  - Then rg_wEpoch toggles with no strobe: epoch_err=2'b01 two edges later.
- Reset mid-stream:
  - Stimulus: 3 records queued, RST_N pulled low off-edge.
  - Required: out_valid=0 and all outputs 0 immediately.
  - After release, no epoch_err is raised from stale history.

Source files
------------

// File: rtl/pc_flow_monitor.sv
// pc_flow_monitor
//   Watches the stage0 fetch-PC register and the stage2 epoch-update strobes.
//   Every PC write is classified and queued as a record. Records drain over a
//   valid/ready stream. Alongside the queue the block:
//     - checks that each epoch bit toggles exactly when its strobe fired in
//       the previous cycle,
//     - keeps sticky overflow and epoch-error flags,
//     - keeps an update counter (wraps) and a drop counter (saturates).
//
// Ports
//   CLK, RST_N                    clock, async active-low reset
//   rg_pc_EN, rg_pc, rg_pc_D_IN   PC write enable, old PC, new PC
//   ma_flush_fl                   flush this cycle
//   rg_fence, rg_sfence           fence / sfence pending
//   rg_eEpoch, rg_wEpoch          stage0 epoch bits
//   EN_update_eEpoch/wEpoch       stage2 epoch-update strobes
//   clr_sticky                    clears overflow, epoch_err, drop_count
//   out_valid/out_ready           record stream handshake
//   out_kind, out_pc_old,
//   out_pc_new, out_epochs        record fields (zero while empty)
//   update_count, drop_count      statistics
//   overflow, epoch_err           sticky flags ({e, w} for epoch_err)

// Per-bit epoch consistency check. Remembers last cycle's bit and strobe
// and flags a bit that did not follow them. hist_vld masks the first cycle
// after reset, when the remembered values mean nothing.
module pc_epoch_chk (
  input  logic CLK,
  input  logic RST_N,
  input  logic hist_vld,
  input  logic ep,
  input  logic stb,
  output logic err
);
  logic prev_ep, prev_stb;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      prev_ep  <= 1'b0;
      prev_stb <= 1'b0;
    end else begin
      prev_ep  <= ep;
      prev_stb <= stb;
    end
  end

  // A strobe flips the expected value; no strobe means it must hold.
  assign err = hist_vld & (ep != (prev_ep ^ prev_stb));
endmodule

module pc_flow_monitor #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 8
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            rg_pc_EN,
  input  logic [XLEN-1:0] rg_pc,
  input  logic [XLEN-1:0] rg_pc_D_IN,
  input  logic            ma_flush_fl,
  input  logic            rg_fence,
  input  logic            rg_sfence,
  input  logic            rg_eEpoch,
  input  logic            rg_wEpoch,
  input  logic            EN_update_eEpoch,
  input  logic            EN_update_wEpoch,
  input  logic            clr_sticky,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2:0]      out_kind,
  output logic [XLEN-1:0] out_pc_old,
  output logic [XLEN-1:0] out_pc_new,
  output logic [1:0]      out_epochs,
  output logic [31:0]     update_count,
  output logic [15:0]     drop_count,
  output logic            overflow,
  output logic [1:0]      epoch_err
);
  localparam int AW       = $clog2(DEPTH);
  localparam int NUM_EPOCH = 2;

  localparam logic [2:0] K_SEQ4  = 3'd0;
  localparam logic [2:0] K_SEQ2  = 3'd1;
  localparam logic [2:0] K_FLUSH = 3'd2;
  localparam logic [2:0] K_FENCE = 3'd3;
  localparam logic [2:0] K_JUMP  = 3'd4;

  typedef struct packed {
    logic [2:0]      kind;
    logic [XLEN-1:0] pc_old;
    logic [XLEN-1:0] pc_new;
    logic [1:0]      epochs;
  } rec_t;

  // ---------------- classification ----------------
  logic [2:0] kind;
  always_comb begin
    kind = K_JUMP;
    if (ma_flush_fl)                              kind = K_FLUSH;
    else if (rg_fence | rg_sfence)                kind = K_FENCE;
    else if (rg_pc_D_IN == rg_pc + XLEN'(4))      kind = K_SEQ4;
    else if (rg_pc_D_IN == rg_pc + XLEN'(2))      kind = K_SEQ2;
  end

  rec_t wr_rec;
  assign wr_rec = '{kind: kind, pc_old: rg_pc, pc_new: rg_pc_D_IN,
                    epochs: {rg_eEpoch, rg_wEpoch}};

  // ---------------- record FIFO ----------------
  // Pointers carry one extra wrap bit: equal pointers mean empty, equal
  // index with differing wrap bit means full.
  rec_t          mem [DEPTH];
  logic [AW:0]   wptr, rptr;
  logic          empty, full, pop, wr_en, drop;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop   = ~empty & out_ready;
  // When full, a same-cycle pop frees the slot the push lands in.
  assign wr_en = rg_pc_EN & (~full | pop);
  assign drop  = rg_pc_EN & full & ~pop;

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wptr[AW-1:0]] <= wr_rec;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (pop)   rptr <= rptr + 1'b1;
    end
  end

  // Head read straight from storage; forced to zero while empty so the
  // outputs are clean after reset without clearing the array.
  rec_t rd_rec;
  assign rd_rec     = mem[rptr[AW-1:0]];
  assign out_valid  = ~empty;
  assign out_kind   = empty ? '0 : rd_rec.kind;
  assign out_pc_old = empty ? '0 : rd_rec.pc_old;
  assign out_pc_new = empty ? '0 : rd_rec.pc_new;
  assign out_epochs = empty ? '0 : rd_rec.epochs;

  // ---------------- epoch checker ----------------
  logic                 hist_vld;
  logic [NUM_EPOCH-1:0] ep_val, ep_stb, ep_err;

  assign ep_val = {rg_eEpoch, rg_wEpoch};
  assign ep_stb = {EN_update_eEpoch, EN_update_wEpoch};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) hist_vld <= 1'b0;
    else        hist_vld <= 1'b1;
  end

  for (genvar g = 0; g < NUM_EPOCH; g++) begin : g_ep
    pc_epoch_chk u_chk (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .hist_vld (hist_vld),
      .ep       (ep_val[g]),
      .stb      (ep_stb[g]),
      .err      (ep_err[g])
    );
  end

  // ---------------- counters and sticky flags ----------------
  // Clear is applied first, so a same-cycle drop or error still lands.
  logic [15:0] drop_base;
  assign drop_base = clr_sticky ? 16'd0 : drop_count;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      update_count <= '0;
      drop_count   <= '0;
      overflow     <= 1'b0;
      epoch_err    <= '0;
    end else begin
      if (rg_pc_EN) update_count <= update_count + 32'd1;
      if (drop && drop_base != 16'hFFFF) drop_count <= drop_base + 16'd1;
      else                               drop_count <= drop_base;
      overflow  <= (overflow & ~clr_sticky) | drop;
      epoch_err <= (epoch_err & ~{NUM_EPOCH{clr_sticky}}) | ep_err;
    end
  end
endmodule

// File: tb/tb_pc_flow_monitor.sv
// Directed bench for pc_flow_monitor. A queue-based reference model follows
// the classification, FIFO, counter and epoch rules; a compare process
// checks every negative clock edge, and literal checks pin the model.
module tb_pc_flow_monitor;
  localparam int XLEN  = 64;
  localparam int DEPTH = 8;

  logic            CLK, RST_N;
  logic            rg_pc_EN, ma_flush_fl, rg_fence, rg_sfence;
  logic [XLEN-1:0] rg_pc, rg_pc_D_IN;
  logic            rg_eEpoch, rg_wEpoch, EN_update_eEpoch, EN_update_wEpoch;
  logic            clr_sticky, out_valid, out_ready, overflow;
  logic [2:0]      out_kind;
  logic [XLEN-1:0] out_pc_old, out_pc_new;
  logic [1:0]      out_epochs, epoch_err;
  logic [31:0]     update_count;
  logic [15:0]     drop_count;

  pc_flow_monitor #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N), .rg_pc_EN(rg_pc_EN), .rg_pc(rg_pc),
    .rg_pc_D_IN(rg_pc_D_IN), .ma_flush_fl(ma_flush_fl), .rg_fence(rg_fence),
    .rg_sfence(rg_sfence), .rg_eEpoch(rg_eEpoch), .rg_wEpoch(rg_wEpoch),
    .EN_update_eEpoch(EN_update_eEpoch), .EN_update_wEpoch(EN_update_wEpoch),
    .clr_sticky(clr_sticky), .out_valid(out_valid), .out_ready(out_ready),
    .out_kind(out_kind), .out_pc_old(out_pc_old), .out_pc_new(out_pc_new),
    .out_epochs(out_epochs), .update_count(update_count),
    .drop_count(drop_count), .overflow(overflow), .epoch_err(epoch_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [2:0]  kind;
    logic [63:0] pc_old;
    logic [63:0] pc_new;
    logic [1:0]  ep;
  } mrec_t;

  mrec_t       q[$];
  logic [31:0] m_upd;
  int          m_drop;
  logic        m_ovf, m_hist;
  logic [1:0]  m_err, m_pv, m_ps;

  function automatic logic [2:0] classify(input logic fl, input logic fe,
                                          input logic [63:0] o, input logic [63:0] n);
    logic [63:0] p4, p2;
    p4 = o + 64'd4;
    p2 = o + 64'd2;
    if (fl)           return 3'd2;
    else if (fe)      return 3'd3;
    else if (n == p4) return 3'd0;
    else if (n == p2) return 3'd1;
    else              return 3'd4;
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      q.delete();
      m_upd = 0; m_drop = 0; m_ovf = 0; m_err = 0;
      m_hist = 0; m_pv = 0; m_ps = 0;
    end else begin
      logic [1:0] cur;
      mrec_t r;
      cur = {rg_eEpoch, rg_wEpoch};
      if (clr_sticky) begin m_drop = 0; m_ovf = 0; m_err = 0; end
      if (q.size() != 0 && out_ready) void'(q.pop_front());
      if (rg_pc_EN) begin
        m_upd++;
        r.kind   = classify(ma_flush_fl, rg_fence | rg_sfence, rg_pc, rg_pc_D_IN);
        r.pc_old = rg_pc;
        r.pc_new = rg_pc_D_IN;
        r.ep     = cur;
        if (q.size() < DEPTH) q.push_back(r);
        else begin
          if (m_drop < 16'hFFFF) m_drop++;
          m_ovf = 1;
        end
      end
      if (m_hist)
        for (int i = 0; i < 2; i++)
          if (cur[i] != (m_ps[i] ? ~m_pv[i] : m_pv[i])) m_err[i] = 1'b1;
      m_pv = cur;
      m_ps = {EN_update_eEpoch, EN_update_wEpoch};
      m_hist = 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge CLK) begin
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      chk("out_kind",   64'(out_kind),   64'(q[0].kind));
      chk("out_pc_old", out_pc_old,      q[0].pc_old);
      chk("out_pc_new", out_pc_new,      q[0].pc_new);
      chk("out_epochs", 64'(out_epochs), 64'(q[0].ep));
    end else begin
      chk("idle_outputs", {out_kind, out_epochs, 59'(out_pc_old | out_pc_new)}, 64'd0);
    end
    chk("update_count", 64'(update_count), 64'(m_upd));
    chk("drop_count",   64'(drop_count),   64'(m_drop));
    chk("overflow",     64'(overflow),     64'(m_ovf));
    chk("epoch_err",    64'(epoch_err),    64'(m_err));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic upd(input logic [63:0] o, input logic [63:0] n);
    rg_pc_EN = 1; rg_pc = o; rg_pc_D_IN = n;
  endtask

  initial begin
    int cnt;
    RST_N = 0; rg_pc_EN = 0; rg_pc = 0; rg_pc_D_IN = 0; ma_flush_fl = 0;
    rg_fence = 0; rg_sfence = 0; rg_eEpoch = 0; rg_wEpoch = 0;
    EN_update_eEpoch = 0; EN_update_wEpoch = 0; clr_sticky = 0; out_ready = 1;
    #2;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_upd",   64'(update_count), 64'd0);
    chk("rst_flags", {overflow, epoch_err, drop_count}, 64'd0);
    #10 RST_N = 1;

    // Sequential flow: +4 then +2.
    upd(64'h8000_0000, 64'h8000_0004);
    tick();
    upd(64'h8000_0004, 64'h8000_0006);
    chk("seq_valid", 64'(out_valid), 64'd1);
    chk("seq_kind0", 64'(out_kind), 64'd0);
    tick();
    rg_pc_EN = 0;
    chk("seq_kind1", 64'(out_kind), 64'd1);
    tick();
    chk("seq_upd", 64'(update_count), 64'd2);

    // Priority.
    upd(64'h8000_0000, 64'h8000_0004); ma_flush_fl = 1; rg_fence = 1;
    tick();
    chk("pri_flush", 64'(out_kind), 64'd2);
    ma_flush_fl = 0;
    tick();
    chk("pri_fence", 64'(out_kind), 64'd3);
    rg_fence = 0; rg_sfence = 1; rg_pc_D_IN = 64'h8000_0002;
    tick();
    chk("pri_sfence", 64'(out_kind), 64'd3);
    rg_sfence = 0; rg_pc_D_IN = 64'h8000_1000;
    tick();
    chk("pri_jump", 64'(out_kind), 64'd4);
    upd(64'hFFFF_FFFF_FFFF_FFFC, 64'h0);
    tick();
    chk("wrap_seq4", 64'(out_kind), 64'd0);
    upd(64'hFFFF_FFFF_FFFF_FFFE, 64'h0);
    tick();
    chk("wrap_seq2", 64'(out_kind), 64'd1);
    rg_pc_EN = 0;
    tick();

    // Overflow: 10 pushes with the consumer stalled.
    out_ready = 0;
    for (int i = 0; i < 10; i++) begin
      upd(64'h1000 + 64'(i) * 16, 64'h1000 + 64'(i) * 16 + ((i % 2) ? 64'd2 : 64'd4));
      tick();
    end
    rg_pc_EN = 0;
    chk("ovf_drop", 64'(drop_count), 64'd2);
    chk("ovf_flag", 64'(overflow), 64'd1);
    clr_sticky = 1;
    tick();
    clr_sticky = 0;
    chk("clr_drop", 64'(drop_count), 64'd0);
    chk("clr_flag", 64'(overflow), 64'd0);
    chk("clr_head", out_pc_old, 64'h1000);

    // Full with simultaneous push and pop.
    out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      upd(64'h2000 + 64'(i) * 16, 64'h9000);
      tick();
    end
    rg_pc_EN = 0;
    chk("pp_drop", 64'(drop_count), 64'd0);
    chk("pp_head", out_pc_old, 64'h1050);
    cnt = 0;
    for (int i = 0; i < 20 && out_valid; i++) begin
      cnt++;
      tick();
    end
    chk("pp_occupancy", 64'(cnt), 64'd8);

    // Epoch checker.
    EN_update_eEpoch = 1;
    tick();
    EN_update_eEpoch = 0; rg_eEpoch = 1;
    tick();
    tick();
    chk("ep_ok", 64'(epoch_err), 64'd0);
    rg_wEpoch = 1;
    tick();
    chk("ep_werr", 64'(epoch_err), 64'd1);
    tick();

    // Reset mid-stream.
    clr_sticky = 1;
    tick();
    clr_sticky = 0; out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      upd(64'h3000 + 64'(i) * 4, 64'h3004 + 64'(i) * 4);
      tick();
    end
    rg_pc_EN = 0;
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    #3 RST_N = 0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_data", {out_kind, out_epochs, 59'(out_pc_old | out_pc_new)}, 64'd0);
    chk("mid_rst_upd", 64'(update_count), 64'd0);
    #8 RST_N = 1;
    tick();
    tick();
    tick();
    chk("post_rst_err", 64'(epoch_err), 64'd0);
    chk("post_rst_valid", 64'(out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
